button_control: RTL

- Upstream stage of clock_controller. Turns four raw board push-buttons into the one-cycle command pulses of the clock_op_t struct that drives i_clock_control.
- Per button: synchronises, debounces and edge-detects the input.
- Tracks the UI mode (display / set time / set alarm) and auto-repeats the UP button while held.
- Arbitrates simultaneous presses so at most one command is issued per cycle.

---
 rtl/common_pkg.sv | 35 +++
 rtl/button_debouncer.sv | 61 ++++++
 rtl/button_control.sv | 139 +++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared types for the clock front panel: command pulses, UI mode and timing helpers.
package common_pkg;

  // One-cycle command pulses consumed by clock_controller.
  typedef struct packed {
    logic clock_do_display_time;
    logic clock_do_set_time;
    logic clock_do_set_alarm;
    logic clock_do_up;
    logic clock_do_left;
    logic clock_do_toggle_alarm;
  } clock_op_t;

  typedef enum logic [1:0] {
    MODE_DISPLAY   = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } ui_mode_t;

  // Number of clock cycles in a span of milliseconds.
  function automatic int unsigned cyc_per_ms(input int unsigned clock_frequency,
                                             input int unsigned ms);
    return (clock_frequency / 1000) * ms;
  endfunction

  // MODE button walks display -> set time -> set alarm -> display.
  function automatic ui_mode_t next_mode(input ui_mode_t m);
    case (m)
      MODE_DISPLAY:  return MODE_SET_TIME;
      MODE_SET_TIME: return MODE_SET_ALARM;
      default:       return MODE_DISPLAY;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-FF synchroniser, polarity fix, debounce and press pulse.
module button_debouncer
  import common_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27_000_000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned DEB_CYC = cyc_per_ms(CLOCK_FREQUENCY, DEBOUNCE_MS);
  localparam int unsigned CNT_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;
  logic             press_q, press_d;
  logic             lvl;

  // Normalise so that pressed reads as 1.
  assign lvl = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  // Count cycles of disagreement; accept the new level once it has been stable long enough.
  always_comb begin
    cnt_d   = '0;
    deb_d   = deb_q;
    press_d = 1'b0;
    if (lvl != deb_q) begin
      if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
        deb_d   = lvl;
        press_d = lvl;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {2{ACTIVE_LOW}};
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      press_q <= press_d;
    end
  end

  assign level_o = deb_q;
  assign press_o = press_q;

endmodule

// File: rtl/button_control.sv
// Front-panel buttons to clock_controller commands: UI mode FSM, UP auto-repeat, arbiter.
module button_control
  import common_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27_000_000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned HOLD_MS         = 500,
  parameter int unsigned REPEAT_MS       = 150,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_left,
  input  logic       i_btn_alarm,
  output clock_op_t  o_clock_control,
  output logic [1:0] o_mode
);

  localparam int unsigned HOLD_CYC = cyc_per_ms(CLOCK_FREQUENCY, HOLD_MS);
  localparam int unsigned REP_CYC  = cyc_per_ms(CLOCK_FREQUENCY, REPEAT_MS);
  localparam int unsigned RPT_MAX  = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int unsigned CNT_W    = $clog2(RPT_MAX + 1);

  logic press_mode, press_up, press_left, press_alarm;
  logic lvl_mode, lvl_up, lvl_left, lvl_alarm;
  logic unused_lvl;

  clock_op_t        op_q, op_d;
  ui_mode_t         mode_q, mode_d;
  logic             startup_q;
  logic             pend_mode_q, pend_mode_d;
  logic             pend_alarm_q, pend_alarm_d;
  logic             pend_left_q, pend_left_d;
  logic             pend_up_q, pend_up_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_phase_q, rpt_phase_d;
  logic             req_mode, req_alarm, req_left, req_up;
  logic             set_mode, rep_fire, mode_chg;

  button_debouncer #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY), .DEBOUNCE_MS(DEBOUNCE_MS), .ACTIVE_LOW(BTN_ACTIVE_LOW))
    u_deb_mode  (.clk_i(i_clk), .rst_i(i_rst), .btn_i(i_btn_mode),  .level_o(lvl_mode),  .press_o(press_mode));
  button_debouncer #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY), .DEBOUNCE_MS(DEBOUNCE_MS), .ACTIVE_LOW(BTN_ACTIVE_LOW))
    u_deb_up    (.clk_i(i_clk), .rst_i(i_rst), .btn_i(i_btn_up),    .level_o(lvl_up),    .press_o(press_up));
  button_debouncer #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY), .DEBOUNCE_MS(DEBOUNCE_MS), .ACTIVE_LOW(BTN_ACTIVE_LOW))
    u_deb_left  (.clk_i(i_clk), .rst_i(i_rst), .btn_i(i_btn_left),  .level_o(lvl_left),  .press_o(press_left));
  button_debouncer #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY), .DEBOUNCE_MS(DEBOUNCE_MS), .ACTIVE_LOW(BTN_ACTIVE_LOW))
    u_deb_alarm (.clk_i(i_clk), .rst_i(i_rst), .btn_i(i_btn_alarm), .level_o(lvl_alarm), .press_o(press_alarm));

  // Only the UP level drives logic; the other held levels are intentionally unused.
  assign unused_lvl = lvl_mode ^ lvl_left ^ lvl_alarm;

  assign set_mode = (mode_q != MODE_DISPLAY);

  // Auto-repeat strobe: first after the hold time, then once per repeat period.
  assign rep_fire = lvl_up & set_mode &
                    (rpt_phase_q ? (rpt_cnt_q == CNT_W'(REP_CYC)) : (rpt_cnt_q == CNT_W'(HOLD_CYC)));

  // A source requests when freshly pressed or still pending; a repeat merges into UP.
  assign req_mode  = press_mode  | pend_mode_q;
  assign req_alarm = press_alarm | pend_alarm_q;
  assign req_left  = press_left  | pend_left_q;
  assign req_up    = press_up    | rep_fire | pend_up_q;

  // Fixed-priority arbiter; losers stay pending, LEFT/UP are validated against the current mode.
  always_comb begin
    op_d         = '0;
    mode_d       = mode_q;
    pend_mode_d  = req_mode;
    pend_alarm_d = req_alarm;
    pend_left_d  = req_left;
    pend_up_d    = req_up;
    if (startup_q) begin
      op_d.clock_do_display_time = 1'b1;
    end else if (req_mode) begin
      pend_mode_d = 1'b0;
      mode_d      = next_mode(mode_q);
      case (mode_d)
        MODE_SET_TIME:  op_d.clock_do_set_time     = 1'b1;
        MODE_SET_ALARM: op_d.clock_do_set_alarm    = 1'b1;
        default:        op_d.clock_do_display_time = 1'b1;
      endcase
    end else if (req_alarm) begin
      pend_alarm_d               = 1'b0;
      op_d.clock_do_toggle_alarm = 1'b1;
    end else if (req_left) begin
      pend_left_d       = 1'b0;
      op_d.clock_do_left = set_mode;
    end else if (req_up) begin
      pend_up_d        = 1'b0;
      op_d.clock_do_up = set_mode;
    end
  end

  assign mode_chg = (mode_d != mode_q);

  // Hold/repeat counter runs only while UP is held in a set mode with no mode change.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q + CNT_W'(1);
    rpt_phase_d = rpt_phase_q;
    if (!lvl_up || !set_mode || mode_chg) begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end else if (rep_fire) begin
      rpt_cnt_d   = CNT_W'(1);
      rpt_phase_d = 1'b1;
    end
  end

  // State and output registers; startup_q marks the first cycle out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q         <= '0;
      mode_q       <= MODE_DISPLAY;
      startup_q    <= 1'b1;
      pend_mode_q  <= 1'b0;
      pend_alarm_q <= 1'b0;
      pend_left_q  <= 1'b0;
      pend_up_q    <= 1'b0;
      rpt_cnt_q    <= '0;
      rpt_phase_q  <= 1'b0;
    end else begin
      op_q         <= op_d;
      mode_q       <= mode_d;
      startup_q    <= 1'b0;
      pend_mode_q  <= pend_mode_d;
      pend_alarm_q <= pend_alarm_d;
      pend_left_q  <= pend_left_d;
      pend_up_q    <= pend_up_d;
      rpt_cnt_q    <= rpt_cnt_d;
      rpt_phase_q  <= rpt_phase_d;
    end
  end

  assign o_clock_control = op_q;
  assign o_mode          = mode_q;

endmodule
